regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and hazard tracker for the 32x32 register file. Three writeback sources share the register file's single write port (`WbData`/`WbRegNum`/`RegWrite`): ALU results, memory load results and JAL link values. Each source has a one-entry holding slot. The block grants one slot per cycle to a registered write stage and exports a pending-write mask that the decode stage uses for hazard stalls.

## Interface
Parameters:
- `DATA_W`, 32: write data width.
- `ADDR_W`, 5: register index width; the register count is 2^`ADDR_W`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `alu_valid` in 1: ALU write request.
- `alu_ready` out 1: ALU request accepted this cycle when high together with `alu_valid`.
- `alu_rd` in `ADDR_W`: ALU destination register.
- `alu_data` in `DATA_W`: ALU write data.
- `mem_valid`, `mem_ready`, `mem_rd`, `mem_data`: load source; same meanings as the `alu_*` ports.
- `link_valid`, `link_ready`, `link_rd`, `link_data`: JAL link source; same meanings as the `alu_*` ports.
- `wb_we` out 1: write enable; drives `RegWrite`.
- `wb_rd` out `ADDR_W`: drives `WbRegNum`.
- `wb_data` out `DATA_W`: drives `WbData`.
- `pend_mask` out 2^`ADDR_W`: bit r is 1 while a write to register r is held in a slot or presented on `wb_*`.

## Operation
- Slots: one per source, each holding {full, rd, data}.
- Handshake: a transfer occurs when `X_valid` and `X_ready` are both 1 in the same cycle. A requester must hold `X_rd` and `X_data` stable while `X_valid`=1 and `X_ready`=0.
- `X_ready` = (slot empty, or slot granted this cycle) AND (`X_rd`==0 OR `pend_mask[X_rd]`==0) AND no same-cycle conflict.
- Same-cycle conflict: two sources valid with the same nonzero rd. Only the higher-priority source sees ready; priority is link > mem > alu.
- `X_ready` therefore depends combinationally on the other sources' valid and rd. This path is intended.
- Ordering rule: at most one in-flight write per register, so commit order equals acceptance order.
- A transfer with rd==0 is accepted (ready follows the rules above) but discarded. The slot is not loaded, no write occurs, and `pend_mask[0]` stays 0.
- Grant, evaluated each cycle over full slots:
  - A full link slot always wins.
  - Otherwise, if only one of mem/alu is full, that one wins.
  - If both are full, the one not granted last wins.
  - `last_grant` updates only on a mem or alu grant. Its reset value is alu, so mem wins the first tie.
- Write stage: each edge, if any slot was granted, `wb_we`<=1 and `wb_rd`/`wb_data` load from the winner, and the winner's slot empties unless refilled on the same edge. If no slot was granted, `wb_we`<=0 and `wb_rd`/`wb_data` hold their values.
- `pend_mask` is combinational: the OR of the decoded rd of every full slot, plus the decoded `wb_rd` when `wb_we`=1.

## Timing
- Reset (async, immediate): all slots empty, `wb_we`=0, `wb_rd`=0, `wb_data`=0, `pend_mask`=0, `last_grant`=alu. Any writes in flight are dropped. All `X_ready` outputs are 1 while the `X_valid` inputs are 0.
- Latency, uncontended: handshake in cycle t; slot full and `pend_mask` bit set in cycle t+1; `wb_we`=1 in cycle t+2; the register file captures the write at the end of cycle t+2; the `pend_mask` bit clears in cycle t+3.
- Throughput:
  - One write per cycle in aggregate.
  - A single uncontended source sustains one write per cycle to distinct registers, because slot drain and refill happen on the same edge.
  - Back-to-back writes to the same register from one source stall 2 cycles each while the bit is pending.
- Contention: a losing slot stays full and its source's ready stays 0 until the slot is granted. The mem/alu round-robin bounds the wait to 1 grant when link is idle.

## Test plan
- Single ALU write: `alu_valid`=1, rd=3, data=0x11 at cycle 0 → `alu_ready`=1; `pend_mask[3]`=1 in cycles 1–2; `wb_we`=1, `wb_rd`=3, `wb_data`=0x11 in cycle 2; `pend_mask`=0 in cycle 3.
- Round-robin: mem and alu both valid every cycle to distinct registers (mem rd=4,6,… and alu rd=5,7,…), link idle → grants alternate mem, alu, mem, …; starting from reset, mem commits first.
- Link priority plus same-rd conflict: cycle 0 link rd=31 and alu rd=31 both valid → only `link_ready`=1. `alu_ready` stays 0 until `pend_mask[31]` clears in cycle 3; then alu is accepted and commits 2 cycles later, after link.
- Register zero: `mem_valid`=1, rd=0, data=0xDEAD → `mem_ready`=1, `wb_we` stays 0, `pend_mask` stays 0.
- Backpressure hold: link, mem and alu slots all full → `wb_we`=1 every cycle for 3 cycles (link, then mem, then alu), and each source's ready stays 0 until its slot is granted.
- Reset mid-operation: deassert `rst_n` while 2 slots are full and `wb_we`=1 → `wb_we`=0 and `pend_mask`=0 immediately. After release, a new ALU write to rd=3 completes with the nominal 2-cycle latency.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bundle between the ALU, load and JAL link sources and the register-file write arbiter.
// The arbiter side uses the slave modport. The requester/observer side uses the master modport.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic                   alu_valid;
    logic                   alu_ready;
    logic [ADDR_W-1:0]      alu_rd;
    logic [DATA_W-1:0]      alu_data;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [ADDR_W-1:0]      mem_rd;
    logic [DATA_W-1:0]      mem_data;
    logic                   link_valid;
    logic                   link_ready;
    logic [ADDR_W-1:0]      link_rd;
    logic [DATA_W-1:0]      link_data;
    logic                   wb_we;
    logic [ADDR_W-1:0]      wb_rd;
    logic [DATA_W-1:0]      wb_data;
    logic [2**ADDR_W-1:0]   pend_mask;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  link_valid, link_rd, link_data,
        output alu_ready, mem_ready, link_ready,
        output wb_we, wb_rd, wb_data, pend_mask
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output link_valid, link_rd, link_data,
        input  alu_ready, mem_ready, link_ready,
        input  wb_we, wb_rd, wb_data, pend_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Three one-entry writeback slots (link > mem/alu round-robin) feeding a registered write port; 2-cycle accept-to-write latency.
// A source's ready drops while its slot waits, its rd is pending, or a higher-priority source targets the same rd this cycle.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int NSRC = 3;
    localparam int NREG = 1 << ADDR_W;
    localparam int ALU  = 0;
    localparam int MEM  = 1;
    localparam int LINK = 2;
    localparam logic LG_ALU = 1'b0;
    localparam logic LG_MEM = 1'b1;

    logic [NSRC-1:0]   in_vld;
    logic [ADDR_W-1:0] in_rd  [NSRC];
    logic [DATA_W-1:0] in_dat [NSRC];

    assign in_vld       = {bus.link_valid, bus.mem_valid, bus.alu_valid};
    assign in_rd[ALU]   = bus.alu_rd;
    assign in_rd[MEM]   = bus.mem_rd;
    assign in_rd[LINK]  = bus.link_rd;
    assign in_dat[ALU]  = bus.alu_data;
    assign in_dat[MEM]  = bus.mem_data;
    assign in_dat[LINK] = bus.link_data;

    logic [NSRC-1:0]   full_q, full_d;
    logic [ADDR_W-1:0] rd_q  [NSRC];
    logic [ADDR_W-1:0] rd_d  [NSRC];
    logic [DATA_W-1:0] dat_q [NSRC];
    logic [DATA_W-1:0] dat_d [NSRC];
    logic              last_q, last_d;
    logic              wb_we_q, wb_we_d;
    logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_dat_q, wb_dat_d;

    logic [NSRC-1:0]   gnt;
    logic [NSRC-1:0]   conflict;
    logic [NSRC-1:0]   rdy;
    logic [NSRC-1:0]   load;
    logic [NREG-1:0]   pend;

    // Link always wins; mem/alu ties go to whichever was not granted last.
    always_comb begin
        gnt = '0;
        if (full_q[LINK]) begin
            gnt[LINK] = 1'b1;
        end else if (full_q[MEM] && full_q[ALU]) begin
            if (last_q == LG_ALU) gnt[MEM] = 1'b1;
            else                  gnt[ALU] = 1'b1;
        end else if (full_q[MEM]) begin
            gnt[MEM] = 1'b1;
        end else if (full_q[ALU]) begin
            gnt[ALU] = 1'b1;
        end
    end

    always_comb begin
        pend = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (full_q[s]) pend[rd_q[s]] = 1'b1;
        end
        if (wb_we_q) pend[wb_rd_q] = 1'b1;
    end

    always_comb begin
        conflict       = '0;
        conflict[MEM]  = in_vld[LINK] && (in_rd[LINK] == in_rd[MEM]) && (in_rd[MEM] != '0);
        conflict[ALU]  = (in_rd[ALU] != '0) &&
                         ((in_vld[LINK] && (in_rd[LINK] == in_rd[ALU])) ||
                          (in_vld[MEM]  && (in_rd[MEM]  == in_rd[ALU])));
        rdy  = '0;
        load = '0;
        for (int s = 0; s < NSRC; s++) begin
            rdy[s]  = (!full_q[s] || gnt[s]) && ((in_rd[s] == '0) || !pend[in_rd[s]]) && !conflict[s];
            load[s] = in_vld[s] && rdy[s] && (in_rd[s] != '0);
        end
    end

    // Drain and refill of the same slot share an edge, so the load wins.
    always_comb begin
        full_d   = full_q;
        rd_d     = rd_q;
        dat_d    = dat_q;
        last_d   = last_q;
        wb_we_d  = |gnt;
        wb_rd_d  = wb_rd_q;
        wb_dat_d = wb_dat_q;
        for (int s = 0; s < NSRC; s++) begin
            if (gnt[s]) begin
                wb_rd_d   = rd_q[s];
                wb_dat_d  = dat_q[s];
                full_d[s] = 1'b0;
            end
            if (load[s]) begin
                full_d[s] = 1'b1;
                rd_d[s]   = in_rd[s];
                dat_d[s]  = in_dat[s];
            end
        end
        if (gnt[MEM])      last_d = LG_MEM;
        else if (gnt[ALU]) last_d = LG_ALU;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            last_q   <= LG_ALU;
            wb_we_q  <= 1'b0;
            wb_rd_q  <= '0;
            wb_dat_q <= '0;
            for (int s = 0; s < NSRC; s++) begin
                rd_q[s]  <= '0;
                dat_q[s] <= '0;
            end
        end else begin
            full_q   <= full_d;
            last_q   <= last_d;
            wb_we_q  <= wb_we_d;
            wb_rd_q  <= wb_rd_d;
            wb_dat_q <= wb_dat_d;
            for (int s = 0; s < NSRC; s++) begin
                rd_q[s]  <= rd_d[s];
                dat_q[s] <= dat_d[s];
            end
        end
    end

    assign bus.alu_ready  = rdy[ALU];
    assign bus.mem_ready  = rdy[MEM];
    assign bus.link_ready = rdy[LINK];
    assign bus.wb_we      = wb_we_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_data    = wb_dat_q;
    assign bus.pend_mask  = pend;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run, all checked cycle by cycle against a behavioural model
// and a per-register commit scoreboard.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: index 0 = alu, 1 = mem, 2 = link.
    bit          m_full [3];
    logic [4:0]  m_rd   [3];
    logic [31:0] m_dat  [3];
    bit          m_we;
    logic [4:0]  m_wrd;
    logic [31:0] m_wdat;
    bit          m_last_mem;
    logic [31:0] sb [32][$];
    bit          seen_rdy [3];
    string       nm [3] = '{"alu", "mem", "link"};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_full[s] = 0; m_rd[s] = '0; m_dat[s] = '0; seen_rdy[s] = 0;
        end
        m_we = 0; m_wrd = '0; m_wdat = '0; m_last_mem = 0;
        for (int r = 0; r < 32; r++) sb[r].delete();
    endtask

    task automatic drive(input int s, input bit v, input logic [4:0] rd, input logic [31:0] d);
        case (s)
            0: begin bus.alu_valid  = v; bus.alu_rd  = rd; bus.alu_data  = d; end
            1: begin bus.mem_valid  = v; bus.mem_rd  = rd; bus.mem_data  = d; end
            default: begin bus.link_valid = v; bus.link_rd = rd; bus.link_data = d; end
        endcase
    endtask

    task automatic idle();
        for (int s = 0; s < 3; s++) drive(s, 0, '0, '0);
    endtask

    // Check one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic step();
        bit          iv [3];
        logic [4:0]  ird [3];
        logic [31:0] idat [3];
        bit          drdy [3];
        bit          er [3];
        int          pc [32];
        int          g;
        bit          conf;
        logic [31:0] emask;
        @(negedge clk);
        iv   = '{bus.alu_valid, bus.mem_valid, bus.link_valid};
        ird  = '{bus.alu_rd, bus.mem_rd, bus.link_rd};
        idat = '{bus.alu_data, bus.mem_data, bus.link_data};
        drdy = '{bus.alu_ready, bus.mem_ready, bus.link_ready};
        for (int r = 0; r < 32; r++) pc[r] = 0;
        for (int s = 0; s < 3; s++) if (m_full[s]) pc[m_rd[s]]++;
        if (m_we) pc[m_wrd]++;
        emask = '0;
        for (int r = 0; r < 32; r++) if (pc[r] > 0) emask[r] = 1'b1;
        g = -1;
        if (m_full[2])                 g = 2;
        else if (m_full[1] && m_full[0]) g = m_last_mem ? 0 : 1;
        else if (m_full[1])            g = 1;
        else if (m_full[0])            g = 0;
        for (int s = 0; s < 3; s++) begin
            conf = 0;
            for (int t = s + 1; t < 3; t++)
                if (iv[t] && ird[t] == ird[s] && ird[s] != 0) conf = 1;
            er[s] = (!m_full[s] || g == s) && (ird[s] == 0 || pc[ird[s]] == 0) && !conf;
            chk({nm[s], "_ready"}, drdy[s], er[s]);
        end
        chk("wb_we", bus.wb_we, m_we);
        chk("wb_rd", bus.wb_rd, m_wrd);
        chk("wb_data", bus.wb_data, m_wdat);
        chk("pend_mask", bus.pend_mask, emask);
        if (bus.wb_we) begin
            chk("sb_inflight", sb[bus.wb_rd].size(), 1);
            if (sb[bus.wb_rd].size() > 0) chk("sb_data", bus.wb_data, sb[bus.wb_rd].pop_front());
        end
        for (int s = 0; s < 3; s++)
            if (iv[s] && er[s] && ird[s] != 0) sb[ird[s]].push_back(idat[s]);
        seen_rdy = drdy;
        if (g >= 0) begin
            m_we = 1; m_wrd = m_rd[g]; m_wdat = m_dat[g]; m_full[g] = 0;
            if (g == 1)      m_last_mem = 1;
            else if (g == 0) m_last_mem = 0;
        end else begin
            m_we = 0;
        end
        for (int s = 0; s < 3; s++)
            if (iv[s] && er[s] && ird[s] != 0) begin
                m_full[s] = 1; m_rd[s] = ird[s]; m_dat[s] = idat[s];
            end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_wb_we", bus.wb_we, 0);
        chk("rst_wb_rd", bus.wb_rd, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_pend", bus.pend_mask, 0);
        chk("rst_ready", {bus.link_ready, bus.mem_ready, bus.alu_ready}, 3'b111);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int          mr;
        int          ar;
        logic [4:0]  commits [$];
        bit          cv [3];
        logic [4:0]  crd [3];
        logic [31:0] cdat [3];
        int          total;

        idle();
        #1;
        // Single ALU write: latency and pend_mask window.
        do_reset();
        drive(0, 1, 5'd3, 32'h11);
        #1 chk("t1_alu_ready", bus.alu_ready, 1);
        step();
        idle();
        #1 chk("t1_pend_c1", bus.pend_mask, 32'h8);
        chk("t1_we_c1", bus.wb_we, 0);
        step();
        chk("t1_we_c2", bus.wb_we, 1);
        chk("t1_rd_c2", bus.wb_rd, 3);
        chk("t1_data_c2", bus.wb_data, 32'h11);
        chk("t1_pend_c2", bus.pend_mask, 32'h8);
        step();
        chk("t1_pend_c3", bus.pend_mask, 0);
        chk("t1_we_c3", bus.wb_we, 0);

        // Round-robin between mem (even rd) and alu (odd rd).
        do_reset();
        mr = 4; ar = 5;
        for (int c = 0; c < 12; c++) begin
            drive(1, 1, mr[4:0], 32'h1000 + mr);
            drive(0, 1, ar[4:0], 32'h2000 + ar);
            step();
            if (bus.wb_we) commits.push_back(bus.wb_rd);
            if (seen_rdy[1]) mr += 2;
            if (seen_rdy[0]) ar += 2;
        end
        idle();
        for (int c = 0; c < 5; c++) step();
        chk("rr_count", commits.size() >= 6, 1);
        for (int i = 0; i < 6 && i < commits.size(); i++) chk("rr_order", commits[i], 4 + i);

        // Link priority and same-rd conflict with alu.
        do_reset();
        drive(2, 1, 5'd31, 32'hAAAA);
        drive(0, 1, 5'd31, 32'hBBBB);
        #1 chk("cf_link_ready", bus.link_ready, 1);
        chk("cf_alu_ready_c0", bus.alu_ready, 0);
        step();
        drive(2, 0, 5'd31, 32'hAAAA);
        #1 chk("cf_alu_ready_c1", bus.alu_ready, 0);
        step();
        chk("cf_alu_ready_c2", bus.alu_ready, 0);
        chk("cf_link_commit", bus.wb_data, 32'hAAAA);
        step();
        chk("cf_alu_ready_c3", bus.alu_ready, 1);
        chk("cf_pend_c3", bus.pend_mask, 0);
        step();
        idle();
        step();
        chk("cf_we_c5", bus.wb_we, 1);
        chk("cf_rd_c5", bus.wb_rd, 31);
        chk("cf_data_c5", bus.wb_data, 32'hBBBB);
        step();

        // Register zero is accepted and discarded.
        do_reset();
        drive(1, 1, 5'd0, 32'hDEAD);
        #1 chk("r0_mem_ready", bus.mem_ready, 1);
        step();
        idle();
        for (int c = 0; c < 3; c++) begin
            chk("r0_we", bus.wb_we, 0);
            chk("r0_pend", bus.pend_mask, 0);
            step();
        end

        // All three slots full: link, mem, alu drain on consecutive cycles.
        do_reset();
        drive(2, 1, 5'd12, 32'hC);
        drive(1, 1, 5'd11, 32'hB);
        drive(0, 1, 5'd10, 32'hA);
        step();
        drive(2, 0, 5'd12, 32'hC);
        drive(1, 1, 5'd14, 32'hE);
        drive(0, 1, 5'd15, 32'hF);
        #1 chk("bp_mem_ready_c1", bus.mem_ready, 0);
        chk("bp_alu_ready_c1", bus.alu_ready, 0);
        step();
        chk("bp_rd_c2", bus.wb_rd, 12);
        chk("bp_mem_ready_c2", bus.mem_ready, 1);
        chk("bp_alu_ready_c2", bus.alu_ready, 0);
        step();
        drive(1, 0, 5'd14, 32'hE);
        chk("bp_rd_c3", bus.wb_rd, 11);
        chk("bp_alu_ready_c3", bus.alu_ready, 1);
        step();
        drive(0, 0, 5'd15, 32'hF);
        chk("bp_we_c4", bus.wb_we, 1);
        chk("bp_rd_c4", bus.wb_rd, 10);
        for (int c = 0; c < 4; c++) step();

        // Reset while two slots are full and a write is presented.
        do_reset();
        drive(1, 1, 5'd4, 32'h44);
        drive(0, 1, 5'd5, 32'h55);
        step();
        drive(1, 1, 5'd6, 32'h66);
        drive(0, 0, 5'd5, 32'h55);
        step();
        idle();
        chk("mr_we_before", bus.wb_we, 1);
        chk("mr_pend_before", bus.pend_mask, 32'h70);
        rst_n = 1'b0;
        #1;
        chk("mr_we_async", bus.wb_we, 0);
        chk("mr_pend_async", bus.pend_mask, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1, 5'd3, 32'h33);
        step();
        idle();
        step();
        chk("mr_we_after", bus.wb_we, 1);
        chk("mr_rd_after", bus.wb_rd, 3);
        chk("mr_data_after", bus.wb_data, 32'h33);
        step();

        // Randomized traffic over a small register range to provoke conflicts and hazards.
        do_reset();
        for (int s = 0; s < 3; s++) begin cv[s] = 0; crd[s] = '0; cdat[s] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 3; s++) begin
                if (!(cv[s] && !seen_rdy[s])) begin
                    cv[s]   = ($urandom_range(0, 9) < 6);
                    crd[s]  = 5'($urandom_range(0, 7));
                    cdat[s] = $urandom;
                end
                drive(s, cv[s], crd[s], cdat[s]);
            end
            step();
        end
        idle();
        for (int c = 0; c < 6; c++) step();
        total = 0;
        for (int r = 0; r < 32; r++) total += sb[r].size();
        chk("sb_drained", total, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
